// File: rtl/de_write_combiner.sv
// Single-word write combiner between a drawing engine and memory: partial writes
// to one address are merged into a byte-masked buffer and written back as one burst.
module de_write_combiner #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_req,
  output logic        de_ack,
  input  logic [17:0] de_addr,
  input  logic [3:0]  de_nbyte,
  input  logic        de_rnw,
  input  logic [31:0] de_w_data,
  output logic [31:0] de_r_data,
  input  logic        flush,
  output logic        busy,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [17:0] mem_addr,
  output logic [3:0]  mem_nbyte,
  output logic        mem_rnw,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOLD   = 3'd1,
    S_WFLUSH = 3'd2,
    S_RREQ   = 3'd3,
    S_RDONE  = 3'd4
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q;
  logic [17:0] buf_addr_q;
  logic [31:0] buf_data_q, buf_data_d;
  logic [3:0]  buf_mask_q, buf_mask_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_rnw_q;
  logic [17:0] mem_addr_q;
  logic [3:0]  mem_nbyte_q;
  logic [31:0] mem_w_data_q, de_r_data_q;
  logic        wr_s, same_s, upd_s, flush_go_s;

  // Overlay the enabled (active-low) bytes of new_w onto old_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  nb);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (!nb[i]) begin
        r[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return r;
  endfunction

  always_comb begin
    wr_s   = de_req & ~de_rnw;
    same_s = (de_addr == buf_addr_q);
    de_ack = 1'b0;
    case (state_q)
      S_IDLE:  de_ack = wr_s;
      S_HOLD:  de_ack = wr_s & same_s;
      S_RDONE: de_ack = 1'b1;
      default: de_ack = 1'b0;
    endcase

    // An all-disabled write is acknowledged but leaves buffer and counter alone.
    upd_s = de_ack & wr_s & (de_nbyte != 4'hF) &
            ((state_q == S_IDLE) | (state_q == S_HOLD));

    buf_data_d = buf_data_q;
    buf_mask_d = buf_mask_q;
    if (upd_s) begin
      buf_data_d = merge_bytes(buf_data_q, de_w_data, de_nbyte);
      buf_mask_d = (state_q == S_IDLE) ? de_nbyte : (buf_mask_q & de_nbyte);
    end else begin
      buf_data_d = buf_data_q;
      buf_mask_d = buf_mask_q;
    end

    cnt_d = 8'd0;
    if (state_q == S_HOLD) begin
      if (upd_s) begin
        cnt_d = 8'd0;
      end else if (de_ack) begin
        cnt_d = cnt_q;
      end else if (cnt_q < TMO) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = 8'd0;
    end

    // A coincident same-address write is merged before the flush is taken.
    flush_go_s = (state_q == S_HOLD) &
                 ((buf_mask_q == 4'h0) | flush | (cnt_d >= TMO) |
                  (de_req & (de_rnw | ~same_s)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      buf_addr_q   <= 18'd0;
      buf_data_q   <= 32'd0;
      buf_mask_q   <= 4'hF;
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_rnw_q    <= 1'b0;
      mem_addr_q   <= 18'd0;
      mem_nbyte_q  <= 4'hF;
      mem_w_data_q <= 32'd0;
      de_r_data_q  <= 32'd0;
    end else begin
      buf_data_q <= buf_data_d;
      buf_mask_q <= buf_mask_d;
      cnt_q      <= cnt_d;
      case (state_q)
        S_IDLE: begin
          if (upd_s) begin
            buf_addr_q <= de_addr;
            state_q    <= S_HOLD;
          end else if (de_req & de_rnw) begin
            mem_req_q   <= 1'b1;
            mem_rnw_q   <= 1'b1;
            mem_addr_q  <= de_addr;
            mem_nbyte_q <= 4'h0;
            state_q     <= S_RREQ;
          end
        end
        S_HOLD: begin
          if (flush_go_s) begin
            mem_req_q    <= 1'b1;
            mem_rnw_q    <= 1'b0;
            mem_addr_q   <= buf_addr_q;
            mem_w_data_q <= buf_data_d;
            mem_nbyte_q  <= buf_mask_d;
            state_q      <= S_WFLUSH;
          end
        end
        S_WFLUSH: begin
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            buf_mask_q <= 4'hF;
            state_q    <= S_IDLE;
          end
        end
        S_RREQ: begin
          if (mem_ack) begin
            de_r_data_q <= mem_r_data;
            mem_req_q   <= 1'b0;
            state_q     <= S_RDONE;
          end
        end
        S_RDONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign mem_req    = mem_req_q;
  assign mem_rnw    = mem_rnw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_nbyte  = mem_nbyte_q;
  assign mem_w_data = mem_w_data_q;
  assign de_r_data  = de_r_data_q;

endmodule
